filtez: RTL and testbench



---
 rtl/filtez_if.sv | 30 +++
 rtl/filtez.sv | 122 ++++++++++++
 tb/tb_filtez.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filtez_if.sv
// filtez_if: block-level handshake, RAM read ports and result of the
// ADPCM zero-section predictor (filtez). The slave modport is the filtez
// side; the master modport is the caller/RAM side.
interface filtez_if;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [2:0]  bli_address0;
  logic        bli_ce0;
  logic [31:0] bli_q0;
  logic [2:0]  dlti_address0;
  logic        dlti_ce0;
  logic [31:0] dlti_q0;
  logic [31:0] ap_return;

  modport slave (
    input  ap_start, bli_q0, dlti_q0,
    output ap_done, ap_idle, ap_ready,
    output bli_address0, bli_ce0, dlti_address0, dlti_ce0,
    output ap_return
  );

  modport master (
    output ap_start, bli_q0, dlti_q0,
    input  ap_done, ap_idle, ap_ready,
    input  bli_address0, bli_ce0, dlti_address0, dlti_ce0,
    input  ap_return
  );
endinterface

// File: rtl/filtez.sv
// filtez: zero-section predictor. Computes sum(bli[i]*dlti[i]) over 6 taps
// in a 64-bit wrapping accumulator and returns it arithmetically shifted
// right by 14, low 32 bits kept.
// Optional build macro FILTEZ_SAT_EN: clamp the shifted sum to the signed
// 32-bit range instead of truncating. Latency is the same in both builds.
module filtez (
  input  logic     ap_clk,
  input  logic     ap_rst,
  filtez_if.slave  bus
);

  localparam int unsigned NTAPS = 6;
  localparam int unsigned SHIFT = 14;
  localparam int unsigned ACC_W = 64;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_FETCH = 4'b0010,
    S_MAC   = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic [31:0]              ret;
  logic                     done_r;
  logic                     ce_r;
  logic [IDX_W-1:0]         addr_r;

  logic signed [ACC_W-1:0]  op_b;
  logic signed [ACC_W-1:0]  op_d;
  logic signed [ACC_W-1:0]  prod;
  logic [31:0]              result_c;

  // Sign-extend both RAM words and form the tap product
  assign op_b = {{(ACC_W-32){bus.bli_q0[31]}}, bus.bli_q0};
  assign op_d = {{(ACC_W-32){bus.dlti_q0[31]}}, bus.dlti_q0};
  assign prod = op_b * op_d;

`ifdef FILTEZ_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [ACC_W-1:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

  logic signed [ACC_W-1:0] shifted;

  // Floor-shift the sum and clamp it to the signed 32-bit range
  always_comb begin
    shifted  = acc >>> SHIFT;
    result_c = shifted[31:0];
    if (shifted > SAT_MAX) begin
      result_c = 32'h7FFF_FFFF;
    end else if (shifted < SAT_MIN) begin
      result_c = 32'h8000_0000;
    end
  end
`else
  // Floor-shift and keep the low 32 bits, bit-exact with the C model
  assign result_c = acc[SHIFT+31:SHIFT];
`endif

  // Control FSM, accumulator and registered outputs
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      acc    <= '0;
      ret    <= '0;
      done_r <= 1'b0;
      ce_r   <= 1'b0;
      addr_r <= '0;
    end else begin
      done_r <= 1'b0;
      ce_r   <= 1'b0;
      addr_r <= '0;
      case (state)
        S_IDLE: begin
          if (bus.ap_start) begin
            acc    <= '0;
            idx    <= '0;
            ce_r   <= 1'b1;
            addr_r <= '0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_MAC;
        end
        S_MAC: begin
          acc <= acc + prod;
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(NTAPS - 1)) begin
            done_r <= 1'b1;
            state  <= S_DONE;
          end else begin
            ce_r   <= 1'b1;
            addr_r <= idx + IDX_W'(1);
            state  <= S_FETCH;
          end
        end
        S_DONE: begin
          ret   <= result_c;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ap_done       = done_r;
  assign bus.ap_ready      = done_r;
  assign bus.ap_idle       = (state == S_IDLE) && !bus.ap_start;
  assign bus.bli_ce0       = ce_r;
  assign bus.dlti_ce0      = ce_r;
  assign bus.bli_address0  = addr_r;
  assign bus.dlti_address0 = addr_r;
  assign bus.ap_return     = ret;

endmodule

// File: tb/tb_filtez.sv
// tb_filtez: directed self-checking bench for the filtez zero-section predictor.
module tb_filtez;

  logic ap_clk;
  logic ap_rst;
  filtez_if bus ();

  filtez dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  int cmp_cnt;
  int err_cnt;

  logic [31:0] bli_mem  [8];
  logic [31:0] dlti_mem [8];

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Single-port read RAMs: data one cycle after ce0
  always @(posedge ap_clk) begin
    if (bus.bli_ce0)  bus.bli_q0  <= bli_mem[bus.bli_address0];
    if (bus.dlti_ce0) bus.dlti_q0 <= dlti_mem[bus.dlti_address0];
  end

  task automatic clear_mem();
    for (int k = 0; k < 8; k++) begin
      bli_mem[k]  = 32'h0;
      dlti_mem[k] = 32'h0;
    end
  endtask

  // Start one run, optionally pulse ap_start at cycle pulse_at, observe it.
  task automatic do_run(input int pulse_at, output int done_n, output int ce_cnt,
                        output bit addr_ok, output bit ready_ok, output logic [31:0] ret);
    bit seen;
    seen     = 1'b0;
    done_n   = -1;
    ce_cnt   = 0;
    addr_ok  = 1'b1;
    ready_ok = 1'b0;
    bus.ap_start = 1'b1;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge ap_clk); #1;
      bus.ap_start = (n == pulse_at);
      if (bus.bli_ce0) begin
        if (bus.bli_address0 != 3'(ce_cnt) || bus.dlti_address0 != 3'(ce_cnt) || !bus.dlti_ce0)
          addr_ok = 1'b0;
        ce_cnt++;
      end else if (bus.dlti_ce0 || bus.bli_address0 != 3'd0 || bus.dlti_address0 != 3'd0) begin
        addr_ok = 1'b0;
      end
      if (bus.ap_done) begin
        seen     = 1'b1;
        done_n   = n;
        ready_ok = bus.ap_ready;
      end
    end
    bus.ap_start = 1'b0;
    @(posedge ap_clk); #1;
    ret = bus.ap_return;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    bus.ap_start = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    cmp_cnt++;
    if (bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_done: done=%b ready=%b required 0/0", bus.ap_done, bus.ap_ready);
    end
    cmp_cnt++;
    if (bus.bli_ce0 !== 1'b0 || bus.dlti_ce0 !== 1'b0 || bus.bli_address0 !== 3'd0 || bus.dlti_address0 !== 3'd0) begin
      err_cnt++;
      $display("FAIL reset_ram: ce=%b/%b addr=%0d/%0d required 0", bus.bli_ce0, bus.dlti_ce0,
               bus.bli_address0, bus.dlti_address0);
    end
    cmp_cnt++;
    if (bus.ap_return !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_return: got %h required 00000000", bus.ap_return);
    end
    cmp_cnt++;
    if (bus.ap_idle !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_idle_lo_start: got %b required 1", bus.ap_idle);
    end
    bus.ap_start = 1'b1;
    #1;
    cmp_cnt++;
    if (bus.ap_idle !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_idle_hi_start: got %b required 0", bus.ap_idle);
    end
    bus.ap_start = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_zero();
    int dn, cc; bit ao, ro; logic [31:0] r;
    clear_mem();
    do_run(0, dn, cc, ao, ro, r);
    cmp_cnt++;
    if (dn !== 13) begin
      err_cnt++;
      $display("FAIL zero_latency: done at cycle %0d required 13", dn);
    end
    cmp_cnt++;
    if (cc !== 6 || ao !== 1'b1) begin
      err_cnt++;
      $display("FAIL zero_fetch: ce cycles %0d addr_ok %b required 6 / 1", cc, ao);
    end
    cmp_cnt++;
    if (ro !== 1'b1) begin
      err_cnt++;
      $display("FAIL zero_ready: ready at done %b required 1", ro);
    end
    cmp_cnt++;
    if (r !== 32'h0) begin
      err_cnt++;
      $display("FAIL zero_return: got %h required 00000000", r);
    end
    cmp_cnt++;
    if (bus.ap_done !== 1'b0 || bus.ap_idle !== 1'b1) begin
      err_cnt++;
      $display("FAIL zero_after: done=%b idle=%b required 0/1", bus.ap_done, bus.ap_idle);
    end
  endtask

  task automatic test_single_tap();
    int dn, cc; bit ao, ro; logic [31:0] r;
    clear_mem();
    bli_mem[0] = 32'd16384; dlti_mem[0] = 32'd1;
    do_run(0, dn, cc, ao, ro, r);
    cmp_cnt++;
    if (r !== 32'h0000_0001) begin
      err_cnt++;
      $display("FAIL tap0_return: got %h required 00000001", r);
    end
    clear_mem();
    bli_mem[5] = -32'sd16384; dlti_mem[5] = 32'd3;
    do_run(0, dn, cc, ao, ro, r);
    cmp_cnt++;
    if (r !== 32'hFFFF_FFFD || dn !== 13) begin
      err_cnt++;
      $display("FAIL tap5_return: got %h at cycle %0d required FFFFFFFD at 13", r, dn);
    end
  endtask

  task automatic test_floor();
    int dn, cc; bit ao, ro; logic [31:0] r;
    clear_mem();
    for (int k = 0; k < 6; k++) begin bli_mem[k] = 32'd1; dlti_mem[k] = 32'd1; end
    do_run(0, dn, cc, ao, ro, r);
    cmp_cnt++;
    if (r !== 32'h0) begin
      err_cnt++;
      $display("FAIL floor_pos6: got %h required 00000000", r);
    end
    for (int k = 0; k < 6; k++) bli_mem[k] = 32'hFFFF_FFFF;
    do_run(0, dn, cc, ao, ro, r);
    cmp_cnt++;
    if (r !== 32'hFFFF_FFFF) begin
      err_cnt++;
      $display("FAIL floor_neg6: got %h required FFFFFFFF", r);
    end
  endtask

  task automatic test_overflow();
    int dn, cc; bit ao, ro; logic [31:0] r;
    logic [31:0] exp_pos, exp_neg;
`ifdef FILTEZ_SAT_EN
    exp_pos = 32'h7FFF_FFFF;
    exp_neg = 32'h8000_0000;
`else
    exp_pos = 32'h0000_0000;
    exp_neg = 32'h0000_0000;
`endif
    clear_mem();
    bli_mem[0] = 32'h4000_0000; dlti_mem[0] = 32'h4000_0000;
    do_run(0, dn, cc, ao, ro, r);
    cmp_cnt++;
    if (r !== exp_pos) begin
      err_cnt++;
      $display("FAIL ovf_pos: got %h required %h", r, exp_pos);
    end
    bli_mem[0] = 32'hC000_0000;
    do_run(0, dn, cc, ao, ro, r);
    cmp_cnt++;
    if (r !== exp_neg || dn !== 13) begin
      err_cnt++;
      $display("FAIL ovf_neg: got %h at cycle %0d required %h at 13", r, dn, exp_neg);
    end
  endtask

  // Mixed taps with an ap_start pulse during S_MAC that must be ignored
  task automatic test_mixed_pulse();
    int dn, cc; bit ao, ro; logic [31:0] r;
    bit extra_done;
    clear_mem();
    bli_mem[0] = 32'd100000;   dlti_mem[0] = 32'd3;
    bli_mem[1] = -32'sd200000; dlti_mem[1] = 32'd5;
    bli_mem[2] = 32'd300000;   dlti_mem[2] = -32'sd7;
    bli_mem[3] = 32'd7;        dlti_mem[3] = 32'd11;
    bli_mem[4] = -32'sd9;      dlti_mem[4] = 32'd13;
    bli_mem[5] = 32'd65536;    dlti_mem[5] = -32'sd2;
    do_run(3, dn, cc, ao, ro, r);
    cmp_cnt++;
    if (dn !== 13 || cc !== 6 || ao !== 1'b1) begin
      err_cnt++;
      $display("FAIL mixed_timing: done %0d ce %0d addr_ok %b required 13 / 6 / 1", dn, cc, ao);
    end
    cmp_cnt++;
    if (r !== 32'hFFFF_FF4D) begin
      err_cnt++;
      $display("FAIL mixed_return: got %h required FFFFFF4D", r);
    end
    extra_done = 1'b0;
    repeat (20) begin
      @(posedge ap_clk); #1;
      if (bus.ap_done || !bus.ap_idle) extra_done = 1'b1;
    end
    cmp_cnt++;
    if (extra_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL pulse_ignored: spurious activity %b required 0", extra_done);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [31:0] r1, r2;
    clear_mem();
    bli_mem[0] = 32'd16384; dlti_mem[0] = 32'd5;
    d1 = -1; d2 = -1; r1 = 32'h0;
    bus.ap_start = 1'b1;
    for (int n = 1; n <= 60 && d2 < 0; n++) begin
      @(posedge ap_clk); #1;
      if (d1 > 0 && n == d1 + 1) r1 = bus.ap_return;
      if (bus.ap_done) begin
        if (d1 < 0) begin
          d1 = n;
          clear_mem();
          bli_mem[2] = -32'sd16384; dlti_mem[2] = 32'd7;
        end else begin
          d2 = n;
          bus.ap_start = 1'b0;
        end
      end
    end
    bus.ap_start = 1'b0;
    @(posedge ap_clk); #1;
    r2 = bus.ap_return;
    cmp_cnt++;
    if (d1 !== 13 || d2 - d1 !== 14) begin
      err_cnt++;
      $display("FAIL b2b_timing: done at %0d and %0d required 13 and 27", d1, d2);
    end
    cmp_cnt++;
    if (r1 !== 32'h0000_0005) begin
      err_cnt++;
      $display("FAIL b2b_first: got %h required 00000005", r1);
    end
    cmp_cnt++;
    if (r2 !== 32'hFFFF_FFF9) begin
      err_cnt++;
      $display("FAIL b2b_second: got %h required FFFFFFF9", r2);
    end
  endtask

  task automatic test_reset_midrun();
    int dn, cc; bit ao, ro; logic [31:0] r;
    bit spurious;
    clear_mem();
    bli_mem[3] = 32'd32768; dlti_mem[3] = 32'd9;
    bus.ap_start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge ap_clk); #1;
      bus.ap_start = 1'b0;
    end
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    cmp_cnt++;
    if (bus.ap_return !== 32'h0 || bus.ap_done !== 1'b0 || bus.ap_idle !== 1'b1 || bus.bli_ce0 !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrun_reset: ret=%h done=%b idle=%b ce=%b required 0/0/1/0",
               bus.ap_return, bus.ap_done, bus.ap_idle, bus.bli_ce0);
    end
    ap_rst = 1'b0;
    spurious = 1'b0;
    repeat (15) begin
      @(posedge ap_clk); #1;
      if (bus.ap_done || bus.bli_ce0) spurious = 1'b1;
    end
    cmp_cnt++;
    if (spurious !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrun_no_done: activity after reset %b required 0", spurious);
    end
    do_run(0, dn, cc, ao, ro, r);
    cmp_cnt++;
    if (dn !== 13 || r !== 32'h0000_0012) begin
      err_cnt++;
      $display("FAIL midrun_restart: got %h at cycle %0d required 00000012 at 13", r, dn);
    end
  endtask

  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    ap_rst = 1'b1;
    bus.ap_start = 1'b0;
    clear_mem();
    test_reset();
    test_zero();
    test_single_tap();
    test_floor();
    test_overflow();
    test_mixed_pulse();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
